// File: rtl/cache_pkg.sv
// Shared constants, FSM encoding and array write-command type for the
// two-way set-associative write-through data cache.
package cache_pkg;

  localparam int SETS       = 64;
  localparam int IDX_W      = 6;
  localparam int TAG_W      = 10;
  localparam int WORD_W     = 32;
  localparam int LINE_W     = 2 * WORD_W;

  // Byte-address fields: bit 2 selects the word, [8:3] index, [18:9] tag.
  localparam int OFFSET_BIT = 2;
  localparam int INDEX_LSB  = 3;
  localparam int TAG_LSB    = 9;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FILL  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;

  // One write port into the set store. fill_en writes a whole line and
  // marks it valid; word_en patches one word; mru_en makes `way` the MRU.
  typedef struct packed {
    logic              fill_en;
    logic              word_en;
    logic              mru_en;
    logic              way;
    logic              word_sel;
    logic [LINE_W-1:0] line;
    logic [WORD_W-1:0] word;
  } wr_cmd_t;

  function automatic logic [WORD_W-1:0] pick_word(input logic [LINE_W-1:0] line,
                                                  input logic              sel);
    return sel ? line[LINE_W-1:WORD_W] : line[WORD_W-1:0];
  endfunction

endpackage

// File: rtl/cache_set_store.sv
// Valid/tag/data/LRU storage for both ways. Lookup is combinational on the
// current index; all updates go through one synchronous write port.
module cache_set_store
  import cache_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  idx,
  input  logic [TAG_W-1:0]  tag,
  input  wr_cmd_t           wr,
  output logic              hit0,
  output logic              hit1,
  output logic              valid0,
  output logic              valid1,
  output logic              lru,
  output logic [LINE_W-1:0] line0,
  output logic [LINE_W-1:0] line1
);

  logic [SETS-1:0]   v0_q;
  logic [SETS-1:0]   v1_q;
  logic [SETS-1:0]   lru_q;
  logic [TAG_W-1:0]  tag0_q  [SETS];
  logic [TAG_W-1:0]  tag1_q  [SETS];
  logic [LINE_W-1:0] data0_q [SETS];
  logic [LINE_W-1:0] data1_q [SETS];

  assign valid0 = v0_q[idx];
  assign valid1 = v1_q[idx];
  assign lru    = lru_q[idx];
  assign line0  = data0_q[idx];
  assign line1  = data1_q[idx];
  assign hit0   = valid0 && (tag0_q[idx] == tag);
  assign hit1   = valid1 && (tag1_q[idx] == tag);

  // Valid and LRU bits: cleared asynchronously so a reset invalidates every line.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v0_q  <= '0;
      v1_q  <= '0;
      lru_q <= '0;
    end else begin
      if (wr.fill_en) begin
        if (wr.way) v1_q[idx] <= 1'b1;
        else        v0_q[idx] <= 1'b1;
      end
      if (wr.mru_en) lru_q[idx] <= ~wr.way;
    end
  end

  // Tag and data payload: no reset needed, contents are qualified by valid.
  always_ff @(posedge clk) begin
    if (wr.fill_en) begin
      if (wr.way) begin
        tag1_q[idx]  <= tag;
        data1_q[idx] <= wr.line;
      end else begin
        tag0_q[idx]  <= tag;
        data0_q[idx] <= wr.line;
      end
    end else if (wr.word_en) begin
      if (wr.way) begin
        if (wr.word_sel) data1_q[idx][LINE_W-1:WORD_W] <= wr.word;
        else             data1_q[idx][WORD_W-1:0]      <= wr.word;
      end else begin
        if (wr.word_sel) data0_q[idx][LINE_W-1:WORD_W] <= wr.word;
        else             data0_q[idx][WORD_W-1:0]      <= wr.word;
      end
    end
  end

endmodule

// File: rtl/cache_controller.sv
// Write-through, no-write-allocate data cache controller. Read hits finish
// in the request cycle; misses and every store go out over the shared SRAM
// port while ready holds the pipeline.
// SRAM handshake: an enable is held high with a stable address/data from the
// first FILL/WRITE cycle until the cycle sram_ready pulses; that cycle
// completes the access and ready returns to 1 in the same cycle.
module cache_controller
  import cache_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              read_en,
  input  logic              write_en,
  input  logic [31:0]       address,
  input  logic [WORD_W-1:0] writeData,
  output logic [WORD_W-1:0] readData,
  output logic              ready,
  output logic              sram_read_en,
  output logic              sram_write_en,
  output logic [31:0]       sram_address,
  output logic [WORD_W-1:0] sram_wdata,
  input  logic [LINE_W-1:0] sram_rdata,
  input  logic              sram_ready,
  output logic [1:0]        state
);

  logic [1:0]        state_q;
  logic [1:0]        state_d;
  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic              wsel;
  logic              hit0;
  logic              hit1;
  logic              valid0;
  logic              valid1;
  logic              lru;
  logic [LINE_W-1:0] line0;
  logic [LINE_W-1:0] line1;
  logic              hit;
  logic              hit_way;
  logic [LINE_W-1:0] hit_line;
  logic              victim;
  wr_cmd_t           wr;
  logic              unused_addr;

  assign idx         = address[INDEX_LSB +: IDX_W];
  assign tag         = address[TAG_LSB +: TAG_W];
  assign wsel        = address[OFFSET_BIT];
  assign unused_addr = ^{address[31:TAG_LSB+TAG_W], address[OFFSET_BIT-1:0]};

  assign hit      = hit0 | hit1;
  assign hit_way  = ~hit0;
  assign hit_line = hit0 ? line0 : line1;
  // Fill an empty way first (way0 preferred), otherwise evict the LRU way.
  assign victim   = !valid0 ? 1'b0 : (!valid1 ? 1'b1 : lru);

  assign sram_address = address;
  assign sram_wdata   = writeData;
  assign state        = state_q;

  cache_set_store u_store (
    .clk    (clk),
    .rst    (rst),
    .idx    (idx),
    .tag    (tag),
    .wr     (wr),
    .hit0   (hit0),
    .hit1   (hit1),
    .valid0 (valid0),
    .valid1 (valid1),
    .lru    (lru),
    .line0  (line0),
    .line1  (line1)
  );

  // Next state, pipeline stall, load data, SRAM enables and array updates.
  always_comb begin
    state_d       = state_q;
    ready         = 1'b1;
    readData      = '0;
    sram_read_en  = 1'b0;
    sram_write_en = 1'b0;
    wr            = '0;
    wr.line       = sram_rdata;
    wr.word       = writeData;
    wr.word_sel   = wsel;
    case (state_q)
      ST_IDLE: begin
        if (write_en) begin
          ready   = 1'b0;
          state_d = ST_WRITE;
          if (hit) begin
            wr.word_en = 1'b1;
            wr.mru_en  = 1'b1;
            wr.way     = hit_way;
          end
        end else if (read_en) begin
          if (hit) begin
            readData  = pick_word(hit_line, wsel);
            wr.mru_en = 1'b1;
            wr.way    = hit_way;
          end else begin
            ready   = 1'b0;
            state_d = ST_FILL;
          end
        end
      end
      ST_FILL: begin
        sram_read_en = 1'b1;
        if (sram_ready) begin
          readData   = pick_word(sram_rdata, wsel);
          wr.fill_en = 1'b1;
          wr.mru_en  = 1'b1;
          wr.way     = victim;
          state_d    = ST_IDLE;
        end else begin
          ready = 1'b0;
        end
      end
      ST_WRITE: begin
        sram_write_en = 1'b1;
        if (sram_ready) state_d = ST_IDLE;
        else            ready   = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register; reset abandons any outstanding SRAM access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

endmodule
